// File: rtl/geofence_pkg.sv
// Shared definitions for the parametrised geofence checker.
//   state_t      : controller states LOAD / SORT / CAL / DONE
//   sort_cycles  : number of vertex pairs (i,j), 1<=i<j<=nv-1, visited by SORT
//   cross_width  : exact width of a 2D cross product of (cw+1)-bit differences
package geofence_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        CAL  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int sort_cycles(input int nv);
        return ((nv - 1) * (nv - 2)) / 2;
    endfunction

    function automatic int cross_width(input int cw);
        return 2 * cw + 3;
    endfunction

    // Values for the default configuration (CW=10, NV=6).
    localparam int CW_DEF = 10;
    localparam int NV_DEF = 6;
    localparam int XW_DEF = cross_width(CW_DEF);
    localparam int S_DEF  = sort_cycles(NV_DEF);

endpackage

// File: rtl/cross2d.sv
// Combinational signed 2D cross product c = a.x*b.y - a.y*b.x.
//   ax, ay, bx, by : signed W-bit operands
//   c              : signed 2W+1-bit result, exact for the full operand range
module cross2d #(
    parameter int W = 11
) (
    input  logic signed [W-1:0] ax,
    input  logic signed [W-1:0] ay,
    input  logic signed [W-1:0] bx,
    input  logic signed [W-1:0] by,
    output logic signed [2*W:0] c
);
    logic signed [2*W-1:0] p1;
    logic signed [2*W-1:0] p2;

    assign p1 = ax * by;
    assign p2 = ay * bx;
    // One guard bit keeps the subtraction of two full-range products exact.
    assign c  = $signed({p1[2*W-1], p1}) - $signed({p2[2*W-1], p2});

endmodule

// File: rtl/geofence_n.sv
// Point-in-convex-polygon checker for NV unordered vertices.
// A job is a target beat followed by NV vertex beats (or the target only when
// reuse=1 and a sorted polygon is held). Vertices are sorted CCW around v0
// with one pair compare/swap per cycle, then each edge is tested against the
// target, one edge per cycle.
//   clk, reset         : clock, asynchronous active-high reset
//   in_valid/in_ready  : input beat handshake (ready only in LOAD)
//   X, Y, reuse        : beat payload; reuse is looked at on the target beat
//   out_valid          : one-cycle result strobe
//   is_inside, on_edge : result flags, meaningful while out_valid=1
module geofence_n
    import geofence_pkg::*;
#(
    parameter int CW            = 10,
    parameter int NV            = 6,
    parameter int ONEDGE_INSIDE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] X,
    input  logic [CW-1:0] Y,
    input  logic          reuse,
    output logic          out_valid,
    output logic          is_inside,
    output logic          on_edge
);
    localparam int            IW     = $clog2(NV);
    localparam int            XW     = cross_width(CW);
    localparam logic [3:0]    NV_C   = 4'(NV);
    localparam logic [IW-1:0] I_LAST = IW'(NV - 1);
    localparam logic [IW-1:0] I_PEN  = IW'(NV - 2);

    function automatic logic signed [CW:0] sdiff(input logic [CW-1:0] a,
                                                 input logic [CW-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            poly_ok_q, poly_ok_d;
    logic [IW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic            any_neg_q, any_neg_d, any_zero_q, any_zero_d;
    logic            out_valid_q, out_valid_d;
    logic            is_inside_q, is_inside_d;
    logic            on_edge_q, on_edge_d;
    logic [CW-1:0]   vx_q [NV];
    logic [CW-1:0]   vy_q [NV];
    logic [CW-1:0]   vx_d [NV];
    logic [CW-1:0]   vy_d [NV];
    logic [CW-1:0]   tx_q, tx_d, ty_q, ty_d;

    logic                 accept;
    logic [IW-1:0]        k_next;
    logic [IW-1:0]        load_idx;
    logic signed [CW:0]   s_ax, s_ay, s_bx, s_by;
    logic signed [CW:0]   e_ax, e_ay, e_bx, e_by;
    logic signed [XW-1:0] c_sort, c_cal;
    logic                 neg_acc, zero_acc;

    assign in_ready  = (state_q == LOAD);
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign is_inside = is_inside_q;
    assign on_edge   = on_edge_q;

    assign k_next   = (k_q == I_LAST) ? '0 : k_q + 1'b1;
    assign load_idx = IW'(cnt_q - 4'd1);

    // Sort operands: vi and vj relative to the pivot v0.
    assign s_ax = sdiff(vx_q[i_q], vx_q[0]);
    assign s_ay = sdiff(vy_q[i_q], vy_q[0]);
    assign s_bx = sdiff(vx_q[j_q], vx_q[0]);
    assign s_by = sdiff(vy_q[j_q], vy_q[0]);

    // Edge test operands: (vk - T) and the edge vector vk -> v(k+1).
    assign e_ax = sdiff(vx_q[k_q], tx_q);
    assign e_ay = sdiff(vy_q[k_q], ty_q);
    assign e_bx = sdiff(vx_q[k_next], vx_q[k_q]);
    assign e_by = sdiff(vy_q[k_next], vy_q[k_q]);

    cross2d #(.W(CW + 1)) u_cross_sort (
        .ax (s_ax), .ay (s_ay), .bx (s_bx), .by (s_by), .c (c_sort)
    );

    cross2d #(.W(CW + 1)) u_cross_cal (
        .ax (e_ax), .ay (e_ay), .bx (e_bx), .by (e_by), .c (c_cal)
    );

    assign neg_acc  = any_neg_q  | c_cal[XW-1];
    assign zero_acc = any_zero_q | (c_cal == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        poly_ok_d   = poly_ok_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        any_neg_d   = any_neg_q;
        any_zero_d  = any_zero_q;
        out_valid_d = 1'b0;
        is_inside_d = is_inside_q;
        on_edge_d   = on_edge_q;
        vx_d        = vx_q;
        vy_d        = vy_q;
        tx_d        = tx_q;
        ty_d        = ty_q;

        case (state_q)
            LOAD: begin
                if (accept) begin
                    if (cnt_q == 4'd0) begin
                        tx_d = X;
                        ty_d = Y;
                        if (reuse && poly_ok_q) begin
                            state_d    = CAL;
                            k_d        = '0;
                            any_neg_d  = 1'b0;
                            any_zero_d = 1'b0;
                        end else begin
                            // Vertex storage is about to be overwritten.
                            cnt_d     = 4'd1;
                            poly_ok_d = 1'b0;
                        end
                    end else begin
                        vx_d[load_idx] = X;
                        vy_d[load_idx] = Y;
                        if (cnt_q == NV_C) begin
                            cnt_d   = 4'd0;
                            state_d = SORT;
                            i_d     = IW'(1);
                            j_d     = IW'(2);
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
            end
            SORT: begin
                // vj lies clockwise of vi around v0: swap so vi stays earliest.
                if (c_sort[XW-1]) begin
                    vx_d[i_q] = vx_q[j_q];
                    vy_d[i_q] = vy_q[j_q];
                    vx_d[j_q] = vx_q[i_q];
                    vy_d[j_q] = vy_q[i_q];
                end
                if (i_q == I_PEN && j_q == I_LAST) begin
                    state_d    = CAL;
                    poly_ok_d  = 1'b1;
                    k_d        = '0;
                    any_neg_d  = 1'b0;
                    any_zero_d = 1'b0;
                end else if (j_q == I_LAST) begin
                    i_d = i_q + 1'b1;
                    j_d = i_q + IW'(2);
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            CAL: begin
                any_neg_d  = neg_acc;
                any_zero_d = zero_acc;
                if (k_q == I_LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    on_edge_d   = zero_acc & ~neg_acc;
                    is_inside_d = ~neg_acc & (~zero_acc | (ONEDGE_INSIDE != 0));
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                state_d = LOAD;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LOAD;
            cnt_q       <= 4'd0;
            poly_ok_q   <= 1'b0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            any_neg_q   <= 1'b0;
            any_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
            is_inside_q <= 1'b0;
            on_edge_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            poly_ok_q   <= poly_ok_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            any_neg_q   <= any_neg_d;
            any_zero_q  <= any_zero_d;
            out_valid_q <= out_valid_d;
            is_inside_q <= is_inside_d;
            on_edge_q   <= on_edge_d;
        end
    end

    // Polygon and target storage carry no reset.
    always_ff @(posedge clk) begin
        vx_q <= vx_d;
        vy_q <= vy_d;
        tx_q <= tx_d;
        ty_q <= ty_d;
    end

endmodule

// File: tb/tb_geofence_n.sv
module tb_geofence_n;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Group A: two NV=4 instances sharing inputs, differing in edge policy.
    logic       a_valid = 1'b0, a_reuse = 1'b0;
    logic [9:0] a_x = '0, a_y = '0;
    logic       a_ready, a_ov, a_in, a_oe;
    logic       e_ready, e_ov, e_in, e_oe;
    // Group B: NV=6 instance.
    logic       b_valid = 1'b0, b_reuse = 1'b0;
    logic [9:0] b_x = '0, b_y = '0;
    logic       b_ready, b_ov, b_in, b_oe;

    int tests = 0;
    int fails = 0;
    int vx [8];
    int vy [8];

    geofence_n #(.CW(10), .NV(4), .ONEDGE_INSIDE(0)) dut4 (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_ready),
        .X(a_x), .Y(a_y), .reuse(a_reuse),
        .out_valid(a_ov), .is_inside(a_in), .on_edge(a_oe)
    );
    geofence_n #(.CW(10), .NV(4), .ONEDGE_INSIDE(1)) dut4e (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(e_ready),
        .X(a_x), .Y(a_y), .reuse(a_reuse),
        .out_valid(e_ov), .is_inside(e_in), .on_edge(e_oe)
    );
    geofence_n #(.CW(10), .NV(6), .ONEDGE_INSIDE(0)) dut6 (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
        .X(b_x), .Y(b_y), .reuse(b_reuse),
        .out_valid(b_ov), .is_inside(b_in), .on_edge(b_oe)
    );

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic beat(input int g, input int x, input int y, input bit r);
        if (g == 0) begin
            a_valid = 1'b1; a_x = 10'(x); a_y = 10'(y); a_reuse = r;
        end else begin
            b_valid = 1'b1; b_x = 10'(x); b_y = 10'(y); b_reuse = r;
        end
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic job(input int g, input int tx, input int ty, input bit r, input int nvert);
        beat(g, tx, ty, r);
        for (int i = 0; i < nvert; i++) beat(g, vx[i], vy[i], 1'b0);
    endtask

    // Current negedge is cycle 1 after the last accept edge.
    task automatic wait_result(input int g, input string name, input int exp_cyc,
                               input bit exp_in, input bit exp_oe, input bit exp_in_e);
        int  cyc = 1;
        bit  ov;
        ov = (g == 0) ? a_ov : b_ov;
        while (!ov && cyc < 60) begin
            @(negedge clk);
            cyc++;
            ov = (g == 0) ? a_ov : b_ov;
        end
        tests++;
        if (!ov) begin
            fails++;
            $display("FAIL %s timeout: no out_valid within %0d cycles, required cycle %0d", name, cyc, exp_cyc);
            return;
        end
        $display("[TB] %s: out_valid at cycle %0d inside=%0b on_edge=%0b", name, cyc,
                 (g == 0) ? a_in : b_in, (g == 0) ? a_oe : b_oe);
        if (cyc !== exp_cyc) begin
            fails++;
            $display("FAIL %s latency: got cycle %0d, required %0d", name, cyc, exp_cyc);
        end
        tests++;
        if (((g == 0) ? a_in : b_in) !== exp_in) begin
            fails++;
            $display("FAIL %s is_inside: got %0b, required %0b", name, (g == 0) ? a_in : b_in, exp_in);
        end
        tests++;
        if (((g == 0) ? a_oe : b_oe) !== exp_oe) begin
            fails++;
            $display("FAIL %s on_edge: got %0b, required %0b", name, (g == 0) ? a_oe : b_oe, exp_oe);
        end
        if (g == 0) begin
            tests++;
            if (e_ov !== 1'b1 || e_in !== exp_in_e || e_oe !== exp_oe) begin
                fails++;
                $display("FAIL %s edge_inside_variant: got ov=%0b in=%0b oe=%0b, required ov=1 in=%0b oe=%0b",
                         name, e_ov, e_in, e_oe, exp_in_e, exp_oe);
            end
        end
        @(negedge clk);
    endtask

    task automatic load_square();
        vx[0] = 10; vy[0] = 10;
        vx[1] = 0;  vy[1] = 0;
        vx[2] = 10; vy[2] = 0;
        vx[3] = 0;  vy[3] = 10;
    endtask

    task automatic load_hexagon();
        vx[0] = 700;  vy[0] = 1023;
        vx[1] = 300;  vy[1] = 0;
        vx[2] = 0;    vy[2] = 300;
        vx[3] = 1023; vy[3] = 0;
        vx[4] = 0;    vy[4] = 1023;
        vx[5] = 1023; vy[5] = 700;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({a_ready, a_ov, a_in, a_oe} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_held_a: got rdy/ov/in/oe=%b, required 1000", {a_ready, a_ov, a_in, a_oe});
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({a_ready, a_ov, a_in, a_oe, e_ready, e_ov} !== 6'b100010) begin
            fails++;
            $display("FAIL reset_a: got %b, required 100010", {a_ready, a_ov, a_in, a_oe, e_ready, e_ov});
        end
        tests++;
        if ({b_ready, b_ov, b_in, b_oe} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_b: got rdy/ov/in/oe=%b, required 1000", {b_ready, b_ov, b_in, b_oe});
        end
        $display("[TB] reset: state checked");
    endtask

    task automatic test_full_inside();
        load_square();
        job(0, 5, 5, 1'b0, 4);
        wait_result(0, "square_full_5_5", 8, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_reuse_cases();
        job(0, 10, 5, 1'b1, 0);
        wait_result(0, "reuse_edge_10_5", 5, 1'b0, 1'b1, 1'b1);
        job(0, 11, 5, 1'b1, 0);
        wait_result(0, "reuse_out_11_5", 5, 1'b0, 1'b0, 1'b0);
        job(0, 10, 15, 1'b1, 0);
        wait_result(0, "reuse_collinear_10_15", 5, 1'b0, 1'b0, 1'b0);
        job(0, 0, 0, 1'b1, 0);
        wait_result(0, "reuse_vertex_0_0", 5, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_hexagon();
        load_hexagon();
        job(1, 1023, 1023, 1'b0, 6);
        wait_result(1, "hex_full_1023_1023", 17, 1'b0, 1'b0, 1'b0);
        job(1, 512, 512, 1'b0, 6);
        wait_result(1, "hex_full_512_512", 17, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        load_square();
        job(0, 5, 5, 1'b0, 4);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (a_ov || e_ov) seen++;
            @(negedge clk);
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL abort_no_out_valid: got %0d strobes, required 0", seen);
        end
        $display("[TB] abort: reset during SORT, strobes seen=%0d", seen);
        // reuse must be ignored now: vertex beats are still required.
        beat(0, 10, 5, 1'b1);
        tests++;
        if (a_ready !== 1'b1 || a_ov !== 1'b0) begin
            fails++;
            $display("FAIL abort_reuse_ignored: got ready=%0b ov=%0b, required ready=1 ov=0", a_ready, a_ov);
        end
        for (int i = 0; i < 4; i++) beat(0, vx[i], vy[i], 1'b0);
        wait_result(0, "abort_then_full_10_5", 8, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        int  busy = 0;
        int  cyc = 1;
        int  ov_cyc = -1;
        bit  got_in = 1'b0, got_oe = 1'b1;
        load_hexagon();
        job(1, 512, 512, 1'b0, 6);
        while (cyc < 60) begin
            if (b_ov) begin
                ov_cyc = cyc; got_in = b_in; got_oe = b_oe;
            end
            if (b_ready) begin
                b_valid = 1'b0;
                break;
            end
            busy++;
            b_valid = 1'b1;
            b_x = 10'($urandom_range(1023));
            b_y = 10'($urandom_range(1023));
            b_reuse = 1'($urandom_range(1));
            @(negedge clk);
            cyc++;
        end
        b_valid = 1'b0;
        $display("[TB] back_to_back: busy=%0d out_valid cycle=%0d inside=%0b on_edge=%0b",
                 busy, ov_cyc, got_in, got_oe);
        tests++;
        if (busy != 17) begin
            fails++;
            $display("FAIL b2b_busy_cycles: got %0d, required 17", busy);
        end
        tests++;
        if (ov_cyc != 17 || got_in !== 1'b1 || got_oe !== 1'b0) begin
            fails++;
            $display("FAIL b2b_result: got cycle=%0d in=%0b oe=%0b, required cycle=17 in=1 oe=0",
                     ov_cyc, got_in, got_oe);
        end
        job(1, 1023, 1023, 1'b1, 0);
        wait_result(1, "b2b_reuse_1023_1023", 7, 1'b0, 1'b0, 1'b0);
        job(1, 0, 600, 1'b1, 0);
        wait_result(1, "b2b_reuse_edge_0_600", 7, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_inside();
        test_reuse_cases();
        test_hexagon();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
